// File: rtl/wb_commit.sv
// ---------------------------------------------------------------------------
// wb_commit -- write-back / commit stage
//
// Registers one instruction per cycle from the previous stage and turns it
// into architectural side effects: a register-file write, a CSR write, an
// exception request or an ertn flush. Every output is decoded from the
// stage register, so results appear one cycle after in_valid.
//
// After an exception or ertn retires, the stage enters SQUASH and bumps
// cur_epoch. Upstream tags each instruction with the epoch it was fetched
// under. While in SQUASH, instructions with a stale tag are dropped. The
// first instruction carrying the current tag returns the stage to RUN.
//
// Parameters
//   DATA_W   width of PC, result, bad address and CSR data
//   NUM_EXC  number of exception request bits (6..8), bit 0 = highest priority
//   EPOCH_W  width of the flush epoch tag
//
// Ports
//   clk, resetn                 clock, synchronous active-low reset
//   in_*                        incoming instruction fields; in_allow is tied 1
//   rf_we/rf_waddr/rf_wdata     register-file write port
//   csr_we/csr_num/csr_wmask/csr_wvalue   CSR write port
//   ex_valid/ex_ecode/ex_esubcode/ex_pc/ex_badv   exception request
//   ertn_flush                  exception-return flush
//   cur_epoch                   current flush epoch
//   debug_wb_*                  trace port
//   retire_cnt                  64-bit count of normally retired instructions;
//                               present only when WB_COMMIT_RETIRE_CNT_EN is
//                               defined
// ---------------------------------------------------------------------------
module wb_commit #(
    parameter int DATA_W  = 32,
    parameter int NUM_EXC = 8,
    parameter int EPOCH_W = 2
) (
    input  logic               clk,
    input  logic               resetn,

    input  logic               in_valid,
    output logic               in_allow,
    input  logic [DATA_W-1:0]  in_pc,
    input  logic [31:0]        in_inst,
    input  logic [EPOCH_W-1:0] in_epoch,
    input  logic               in_gr_we,
    input  logic [4:0]         in_dest,
    input  logic [DATA_W-1:0]  in_result,
    input  logic [DATA_W-1:0]  in_badv,
    input  logic [NUM_EXC-1:0] in_exc,
    input  logic               in_ertn,
    input  logic               in_csr_we,
    input  logic [13:0]        in_csr_num,
    input  logic [DATA_W-1:0]  in_csr_wmask,
    input  logic [DATA_W-1:0]  in_csr_wvalue,

    output logic               rf_we,
    output logic [4:0]         rf_waddr,
    output logic [DATA_W-1:0]  rf_wdata,
    output logic               csr_we,
    output logic [13:0]        csr_num,
    output logic [DATA_W-1:0]  csr_wmask,
    output logic [DATA_W-1:0]  csr_wvalue,

    output logic               ex_valid,
    output logic [5:0]         ex_ecode,
    output logic [8:0]         ex_esubcode,
    output logic [DATA_W-1:0]  ex_pc,
    output logic [DATA_W-1:0]  ex_badv,
    output logic               ertn_flush,
    output logic [EPOCH_W-1:0] cur_epoch,

    output logic [DATA_W-1:0]  debug_wb_pc,
    output logic [3:0]         debug_wb_rf_we,
    output logic [4:0]         debug_wb_rf_wnum,
    output logic [DATA_W-1:0]  debug_wb_rf_wdata
`ifdef WB_COMMIT_RETIRE_CNT_EN
    ,
    output logic [63:0]        retire_cnt
`endif
);

    typedef enum logic {
        ST_RUN    = 1'b0,
        ST_SQUASH = 1'b1
    } state_e;

    // Control state
    logic               valid_q,     valid_d;
    state_e             state_q,     state_d;
    logic [EPOCH_W-1:0] cur_epoch_q, cur_epoch_d;

    // Stage register payload
    logic [DATA_W-1:0]  pc_q,         pc_d;
    logic [31:0]        inst_q,       inst_d;
    logic               gr_we_q,      gr_we_d;
    logic [4:0]         dest_q,       dest_d;
    logic [DATA_W-1:0]  result_q,     result_d;
    logic [DATA_W-1:0]  badv_q,       badv_d;
    logic [NUM_EXC-1:0] exc_q,        exc_d;
    logic               ertn_q,       ertn_d;
    logic               csr_we_q,     csr_we_d;
    logic [13:0]        csr_num_q,    csr_num_d;
    logic [DATA_W-1:0]  csr_wmask_q,  csr_wmask_d;
    logic [DATA_W-1:0]  csr_wvalue_q, csr_wvalue_d;

    logic accept;
    logic exc_any;
    logic flush;
    logic retire;
    logic [2:0] win_idx;

    // The instruction word is carried for tracing only; nothing here decodes it.
    logic unused_inst;
    assign unused_inst = ^inst_q;

    assign in_allow = 1'b1;

    // Stale-epoch instructions are only dropped while a flush is outstanding.
    assign accept  = in_valid & ((state_q == ST_RUN) | (in_epoch == cur_epoch_q));
    assign exc_any = |exc_q;
    assign flush   = valid_q & (exc_any | ertn_q);
    assign retire  = valid_q & ~exc_any & ~ertn_q;

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves it unassigned; that keeps this block free of latches.
        valid_d      = accept;
        state_d      = state_q;
        cur_epoch_d  = cur_epoch_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        gr_we_d      = gr_we_q;
        dest_d       = dest_q;
        result_d     = result_q;
        badv_d       = badv_q;
        exc_d        = exc_q;
        ertn_d       = ertn_q;
        csr_we_d     = csr_we_q;
        csr_num_d    = csr_num_q;
        csr_wmask_d  = csr_wmask_q;
        csr_wvalue_d = csr_wvalue_q;

        // Payload is captured whenever in_valid is high; whether it counts
        // is decided solely by valid_q.
        if (in_valid) begin
            pc_d         = in_pc;
            inst_d       = in_inst;
            gr_we_d      = in_gr_we;
            dest_d       = in_dest;
            result_d     = in_result;
            badv_d       = in_badv;
            exc_d        = in_exc;
            ertn_d       = in_ertn;
            csr_we_d     = in_csr_we;
            csr_num_d    = in_csr_num;
            csr_wmask_d  = in_csr_wmask;
            csr_wvalue_d = in_csr_wvalue;
        end

        // A retiring flush always opens a new epoch, even when already in
        // SQUASH: back-to-back exceptions each get their own epoch. A new
        // flush wins over leaving SQUASH on the same edge.
        if (flush) begin
            state_d     = ST_SQUASH;
            cur_epoch_d = cur_epoch_q + EPOCH_W'(1);
        end else if ((state_q == ST_SQUASH) && accept) begin
            state_d = ST_RUN;
        end
    end

    // ---------------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its _d value from before the edge, independent of statement
    // order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid_q     <= 1'b0;
            state_q     <= ST_RUN;
            cur_epoch_q <= '0;
        end else begin
            valid_q     <= valid_d;
            state_q     <= state_d;
            cur_epoch_q <= cur_epoch_d;
        end
    end

    // NOTE: payload flops have no reset; valid_q qualifies every use, so
    // leaving them unreset saves reset routing without changing behaviour.
    always_ff @(posedge clk) begin
        pc_q         <= pc_d;
        inst_q       <= inst_d;
        gr_we_q      <= gr_we_d;
        dest_q       <= dest_d;
        result_q     <= result_d;
        badv_q       <= badv_d;
        exc_q        <= exc_d;
        ertn_q       <= ertn_d;
        csr_we_q     <= csr_we_d;
        csr_num_q    <= csr_num_d;
        csr_wmask_q  <= csr_wmask_d;
        csr_wvalue_q <= csr_wvalue_d;
    end

    // ---------------------------------------------------------------------
    // Exception priority: lowest set index wins
    // ---------------------------------------------------------------------
    always_comb begin
        win_idx = 3'd0;
        for (int i = NUM_EXC - 1; i >= 0; i--) begin
            if (exc_q[i]) win_idx = 3'(i);
        end
    end

    always_comb begin
        ex_ecode    = 6'h00;
        ex_esubcode = 9'd0;
        case (win_idx)
            3'd0:    ex_ecode = 6'h00;                       // INT
            3'd1:    ex_ecode = 6'h08;                       // ADEF
            3'd2:    ex_ecode = 6'h0D;                       // INE
            3'd3:    ex_ecode = 6'h0B;                       // SYS
            3'd4:    ex_ecode = 6'h0C;                       // BRK
            3'd5:    ex_ecode = 6'h09;                       // ALE
            3'd6:    begin ex_ecode = 6'h08; ex_esubcode = 9'd1; end  // ADEM
            default: ex_ecode = 6'h3F;                       // reserved
        endcase
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign ex_valid   = valid_q & exc_any;
    assign ex_pc      = pc_q;
    // A fetch-address fault reports the faulting PC as the bad address.
    assign ex_badv    = (win_idx == 3'd1) ? pc_q : badv_q;
    assign ertn_flush = valid_q & ertn_q & ~exc_any;
    assign cur_epoch  = cur_epoch_q;

    // r0 writes are still reported; the register file discards them.
    assign rf_we      = valid_q & gr_we_q & ~exc_any & ~ertn_q;
    assign rf_waddr   = dest_q;
    assign rf_wdata   = result_q;

    assign csr_we     = valid_q & csr_we_q & ~exc_any;
    assign csr_num    = csr_num_q;
    assign csr_wmask  = csr_wmask_q;
    assign csr_wvalue = csr_wvalue_q;

    assign debug_wb_pc       = pc_q;
    assign debug_wb_rf_we    = {4{rf_we}};
    assign debug_wb_rf_wnum  = dest_q;
    assign debug_wb_rf_wdata = result_q;

`ifdef WB_COMMIT_RETIRE_CNT_EN
    logic [63:0] retire_cnt_q, retire_cnt_d;

    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (retire) retire_cnt_d = retire_cnt_q + 64'd1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) retire_cnt_q <= '0;
        else         retire_cnt_q <= retire_cnt_d;
    end

    assign retire_cnt = retire_cnt_q;
`else
    logic unused_retire;
    assign unused_retire = retire;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// ---------------------------------------------------------------------------
// tb_wb_commit -- self-checking bench for wb_commit (default parameters)
//
// Phase 1: reset state.
// Phase 2: directed vector table with hand-computed expectations.
// Phase 3: hand sequences (reset during SQUASH, retire counter).
// Phase 4: random stimulus against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_wb_commit;

    localparam int DATA_W  = 32;
    localparam int NUM_EXC = 8;
    localparam int EPOCH_W = 2;
    localparam int N_EPOCH = 1 << EPOCH_W;

    logic               clk = 1'b0;
    logic               resetn;
    logic               in_valid;
    logic               in_allow;
    logic [DATA_W-1:0]  in_pc;
    logic [31:0]        in_inst;
    logic [EPOCH_W-1:0] in_epoch;
    logic               in_gr_we;
    logic [4:0]         in_dest;
    logic [DATA_W-1:0]  in_result;
    logic [DATA_W-1:0]  in_badv;
    logic [NUM_EXC-1:0] in_exc;
    logic               in_ertn;
    logic               in_csr_we;
    logic [13:0]        in_csr_num;
    logic [DATA_W-1:0]  in_csr_wmask;
    logic [DATA_W-1:0]  in_csr_wvalue;
    logic               rf_we;
    logic [4:0]         rf_waddr;
    logic [DATA_W-1:0]  rf_wdata;
    logic               csr_we;
    logic [13:0]        csr_num;
    logic [DATA_W-1:0]  csr_wmask;
    logic [DATA_W-1:0]  csr_wvalue;
    logic               ex_valid;
    logic [5:0]         ex_ecode;
    logic [8:0]         ex_esubcode;
    logic [DATA_W-1:0]  ex_pc;
    logic [DATA_W-1:0]  ex_badv;
    logic               ertn_flush;
    logic [EPOCH_W-1:0] cur_epoch;
    logic [DATA_W-1:0]  debug_wb_pc;
    logic [3:0]         debug_wb_rf_we;
    logic [4:0]         debug_wb_rf_wnum;
    logic [DATA_W-1:0]  debug_wb_rf_wdata;
`ifdef WB_COMMIT_RETIRE_CNT_EN
    logic [63:0]        retire_cnt;
`endif

    wb_commit #(.DATA_W(DATA_W), .NUM_EXC(NUM_EXC), .EPOCH_W(EPOCH_W)) dut (
        .clk(clk), .resetn(resetn),
        .in_valid(in_valid), .in_allow(in_allow), .in_pc(in_pc), .in_inst(in_inst),
        .in_epoch(in_epoch), .in_gr_we(in_gr_we), .in_dest(in_dest),
        .in_result(in_result), .in_badv(in_badv), .in_exc(in_exc), .in_ertn(in_ertn),
        .in_csr_we(in_csr_we), .in_csr_num(in_csr_num), .in_csr_wmask(in_csr_wmask),
        .in_csr_wvalue(in_csr_wvalue),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .csr_we(csr_we), .csr_num(csr_num), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .ex_valid(ex_valid), .ex_ecode(ex_ecode), .ex_esubcode(ex_esubcode),
        .ex_pc(ex_pc), .ex_badv(ex_badv), .ertn_flush(ertn_flush), .cur_epoch(cur_epoch),
        .debug_wb_pc(debug_wb_pc), .debug_wb_rf_we(debug_wb_rf_we),
        .debug_wb_rf_wnum(debug_wb_rf_wnum), .debug_wb_rf_wdata(debug_wb_rf_wdata)
`ifdef WB_COMMIT_RETIRE_CNT_EN
        , .retire_cnt(retire_cnt)
`endif
    );

    always #5 clk = ~clk;

    // -----------------------------------------------------------------------
    // Stimulus / expectation records
    // -----------------------------------------------------------------------
    typedef struct packed {
        logic        v;
        logic [1:0]  ep;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] result;
        logic [31:0] pc;
        logic [31:0] badv;
        logic [7:0]  exc;
        logic        ertn;
        logic        csr_we;
        logic [13:0] csr_num;
        logic [31:0] wmask;
        logic [31:0] wvalue;
    } stim_t;

    typedef struct packed {
        stim_t       s;
        logic        rf_we;
        logic        ex_v;
        logic [5:0]  ecode;
        logic [8:0]  esub;
        logic [31:0] xbadv;
        logic        ertn_f;
        logic        csr_we;
        logic [1:0]  epoch;
    } vec_t;

    function automatic stim_t mk(input logic v, input logic [1:0] ep, input logic gr_we,
                                 input logic [4:0] dest, input logic [31:0] result,
                                 input logic [31:0] pc, input logic [31:0] badv,
                                 input logic [7:0] exc, input logic ertn, input logic csr_we);
        stim_t s;
        s.v = v; s.ep = ep; s.gr_we = gr_we; s.dest = dest; s.result = result;
        s.pc = pc; s.badv = badv; s.exc = exc; s.ertn = ertn; s.csr_we = csr_we;
        s.csr_num = 14'h180 + 14'(dest);
        s.wmask   = 32'hFFFF_0000 ^ result;
        s.wvalue  = ~result;
        return s;
    endfunction

    function automatic vec_t vx(input stim_t s, input logic rf, input logic exv,
                                input logic [5:0] ecode, input logic [8:0] esub,
                                input logic [31:0] xbadv, input logic ertn_f,
                                input logic cw, input logic [1:0] epoch);
        vec_t t;
        t.s = s; t.rf_we = rf; t.ex_v = exv; t.ecode = ecode; t.esub = esub;
        t.xbadv = xbadv; t.ertn_f = ertn_f; t.csr_we = cw; t.epoch = epoch;
        return t;
    endfunction

    // -----------------------------------------------------------------------
    // Checking
    // -----------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: one commit slot, a squash flag and an epoch counter,
    // updated from the architectural rules once per clock edge.
    // -----------------------------------------------------------------------
    stim_t       m_e;
    bit          m_valid;
    bit          m_squash;
    int          m_epoch;
    logic [63:0] m_cnt;

    int ecode_tab[8] = '{'h00, 'h08, 'h0D, 'h0B, 'h0C, 'h09, 'h08, 'h3F};
    int esub_tab[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};

    // Index of the lowest set bit: isolate it, then take its log2.
    function automatic int low_idx(input logic [7:0] e);
        logic [7:0] lsb;
        lsb = e & (~e + 8'd1);
        return $clog2(int'(lsb));
    endfunction

    task automatic model_step(input stim_t s);
        bit flush, acc;
        if (!resetn) begin
            m_valid  = 0;
            m_squash = 0;
            m_epoch  = 0;
            m_cnt    = '0;
        end else begin
            flush = m_valid && (m_e.exc != 0 || m_e.ertn);
            acc   = s.v && (!m_squash || int'(s.ep) == m_epoch);
            if (m_valid && m_e.exc == 0 && !m_e.ertn) m_cnt = m_cnt + 1;
            if (flush) begin
                m_squash = 1;
                m_epoch  = (m_epoch + 1) % N_EPOCH;
            end else if (m_squash && acc) begin
                m_squash = 0;
            end
            m_valid = acc;
        end
        if (s.v) m_e = s;
    endtask

    task automatic drive(input stim_t s);
        in_valid      = s.v;
        in_epoch      = s.ep;
        in_gr_we      = s.gr_we;
        in_dest       = s.dest;
        in_result     = s.result;
        in_pc         = s.pc;
        in_badv       = s.badv;
        in_exc        = s.exc;
        in_ertn       = s.ertn;
        in_csr_we     = s.csr_we;
        in_csr_num    = s.csr_num;
        in_csr_wmask  = s.wmask;
        in_csr_wvalue = s.wvalue;
        in_inst       = $urandom;
        @(posedge clk);
        model_step(s);
        #1;
    endtask

    task automatic check_model(input int cyc);
        bit ok_entry, exp_ex, exp_rf;
        int idx;
        ok_entry = m_valid && m_e.exc == 0;
        exp_ex   = m_valid && m_e.exc != 0;
        exp_rf   = ok_entry && !m_e.ertn && m_e.gr_we;
        check($sformatf("r%0d rf_we", cyc), rf_we, exp_rf);
        check($sformatf("r%0d csr_we", cyc), csr_we, ok_entry && m_e.csr_we);
        check($sformatf("r%0d ex_valid", cyc), ex_valid, exp_ex);
        check($sformatf("r%0d ertn_flush", cyc), ertn_flush, ok_entry && m_e.ertn);
        check($sformatf("r%0d cur_epoch", cyc), cur_epoch, m_epoch);
        check($sformatf("r%0d dbg_rf_we", cyc), debug_wb_rf_we, exp_rf ? 4'hF : 4'h0);
        if (m_valid) begin
            check($sformatf("r%0d dbg_pc", cyc), debug_wb_pc, m_e.pc);
            check($sformatf("r%0d waddr", cyc), rf_waddr, m_e.dest);
            check($sformatf("r%0d wdata", cyc), rf_wdata, m_e.result);
            check($sformatf("r%0d dbg_wnum", cyc), debug_wb_rf_wnum, m_e.dest);
            check($sformatf("r%0d dbg_wdata", cyc), debug_wb_rf_wdata, m_e.result);
            check($sformatf("r%0d csr_num", cyc), csr_num, m_e.csr_num);
            check($sformatf("r%0d csr_wmask", cyc), csr_wmask, m_e.wmask);
            check($sformatf("r%0d csr_wvalue", cyc), csr_wvalue, m_e.wvalue);
        end
        if (exp_ex) begin
            idx = low_idx(m_e.exc);
            check($sformatf("r%0d ecode", cyc), ex_ecode, ecode_tab[idx]);
            check($sformatf("r%0d esub", cyc), ex_esubcode, esub_tab[idx]);
            check($sformatf("r%0d ex_pc", cyc), ex_pc, m_e.pc);
            check($sformatf("r%0d ex_badv", cyc), ex_badv, idx == 1 ? m_e.pc : m_e.badv);
        end
`ifdef WB_COMMIT_RETIRE_CNT_EN
        check($sformatf("r%0d retire_cnt", cyc), retire_cnt, m_cnt);
`endif
    endtask

    task automatic check_strobes_idle(input string tag);
        check({tag, " rf_we"}, rf_we, 0);
        check({tag, " csr_we"}, csr_we, 0);
        check({tag, " ex_valid"}, ex_valid, 0);
        check({tag, " ertn_flush"}, ertn_flush, 0);
        check({tag, " cur_epoch"}, cur_epoch, 0);
    endtask

    // -----------------------------------------------------------------------
    // Test sequence
    // -----------------------------------------------------------------------
    localparam int NV = 19;
    vec_t  tab[NV];
    stim_t idle;

    initial begin
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_e  = idle;

        // Directed table; epoch column is cur_epoch after the vector's edge.
        tab[0]  = vx(mk(1,0,1,5,'h1234,'h1C000000,'h0,'h00,0,0), 1,0,'h00,0,0,           0,0,0);
        tab[1]  = vx(mk(1,0,1,3,'h5,   'h1C000040,'hDEAD,'h0A,0,0),0,1,'h08,0,'h1C000040,0,0,0);
        tab[2]  = vx(idle,                                        0,0,'h00,0,0,           0,0,1);
        tab[3]  = vx(mk(1,0,1,6,'h66,  'h1C000044,'h0,'h00,0,0),  0,0,'h00,0,0,           0,0,1);
        tab[4]  = vx(mk(1,0,1,6,'h67,  'h1C000048,'h0,'h00,0,0),  0,0,'h00,0,0,           0,0,1);
        tab[5]  = vx(mk(1,0,1,6,'h68,  'h1C00004C,'h0,'h00,0,0),  0,0,'h00,0,0,           0,0,1);
        tab[6]  = vx(mk(1,1,1,7,'h77,  'h1C000050,'h0,'h00,0,0),  1,0,'h00,0,0,           0,0,1);
        tab[7]  = vx(mk(1,1,1,8,'h88,  'h1C000054,'h0,'h00,1,1),  0,0,'h00,0,0,           1,1,1);
        tab[8]  = vx(idle,                                        0,0,'h00,0,0,           0,0,2);
        tab[9]  = vx(mk(1,2,1,9,'h0,   'h1C000060,'hBAD0,'h08,1,1),0,1,'h0B,0,'hBAD0,     0,0,2);
        tab[10] = vx(idle,                                        0,0,'h00,0,0,           0,0,3);
        tab[11] = vx(mk(1,3,0,0,'h0,   'h1C000070,'h55,'h40,0,0), 0,1,'h08,1,'h55,        0,0,3);
        tab[12] = vx(idle,                                        0,0,'h00,0,0,           0,0,0);
        tab[13] = vx(mk(1,0,0,0,'h0,   'h1C000080,'h99,'h80,0,0), 0,1,'h3F,0,'h99,        0,0,0);
        tab[14] = vx(idle,                                        0,0,'h00,0,0,           0,0,1);
        tab[15] = vx(mk(1,1,0,0,'h0,   'h1C000090,'hA5,'h21,0,0), 0,1,'h00,0,'hA5,        0,0,1);
        tab[16] = vx(mk(1,1,1,4,'h44,  'h1C000094,'hB6,'h04,0,0), 0,1,'h0D,0,'hB6,        0,0,2);
        tab[17] = vx(idle,                                        0,0,'h00,0,0,           0,0,3);
        tab[18] = vx(mk(1,3,1,0,'hF0,  'h1C0000A0,'h0,'h00,0,1),  1,0,'h00,0,0,           0,1,3);

        // Phase 1: reset
        resetn = 1'b0;
        drive(idle);
        drive(idle);
        check_strobes_idle("reset");
        check("reset dbg_rf_we", debug_wb_rf_we, 0);
        check("reset in_allow", in_allow, 1);
        resetn = 1'b1;

        // Phase 2: directed table
        for (int i = 0; i < NV; i++) begin
            drive(tab[i].s);
            check($sformatf("v%0d rf_we", i), rf_we, tab[i].rf_we);
            check($sformatf("v%0d dbg_rf_we", i), debug_wb_rf_we, tab[i].rf_we ? 4'hF : 4'h0);
            check($sformatf("v%0d ex_valid", i), ex_valid, tab[i].ex_v);
            check($sformatf("v%0d ertn_flush", i), ertn_flush, tab[i].ertn_f);
            check($sformatf("v%0d csr_we", i), csr_we, tab[i].csr_we);
            check($sformatf("v%0d cur_epoch", i), cur_epoch, tab[i].epoch);
            if (tab[i].rf_we) begin
                check($sformatf("v%0d waddr", i), rf_waddr, tab[i].s.dest);
                check($sformatf("v%0d wdata", i), rf_wdata, tab[i].s.result);
            end
            if (tab[i].ex_v) begin
                check($sformatf("v%0d ecode", i), ex_ecode, tab[i].ecode);
                check($sformatf("v%0d esub", i), ex_esubcode, tab[i].esub);
                check($sformatf("v%0d ex_pc", i), ex_pc, tab[i].s.pc);
                check($sformatf("v%0d ex_badv", i), ex_badv, tab[i].xbadv);
            end
        end

        // Phase 3a: reset while squashing
        drive(mk(1,3,0,0,0,'h1C0000B0,'h1,'h10,0,0));
        check("h1 ex_valid", ex_valid, 1);
        check("h1 ecode", ex_ecode, 'h0C);
        drive(idle);
        check("h2 cur_epoch", cur_epoch, 0);
        drive(mk(1,3,1,2,'h22,'h1C0000B4,0,0,0,0));
        check("h3 stale dropped", rf_we, 0);
        resetn = 1'b0;
        drive(mk(1,3,1,2,'h23,'h1C0000B8,0,0,0,0));
        check_strobes_idle("h4 reset");
        resetn = 1'b1;
        drive(mk(1,2,1,9,'h99,'h1C0000BC,0,0,0,0));
        check("h5 run accepts", rf_we, 1);
        check("h5 waddr", rf_waddr, 9);
        check("h5 cur_epoch", cur_epoch, 0);

        // Phase 3b: 10 normal retirements then an exception
        resetn = 1'b0;
        drive(idle);
        resetn = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(mk(1,0,1,5'(i+1),32'(i*7),32'h1C001000 + 32'(4*i),0,0,0,0));
            check($sformatf("cnt%0d rf_we", i), rf_we, 1);
        end
        drive(mk(1,0,1,1,0,'h1C002000,'h7,'h20,0,0));
        check("cnt exc ex_valid", ex_valid, 1);
        check("cnt exc ecode", ex_ecode, 'h09);
        drive(idle);
`ifdef WB_COMMIT_RETIRE_CNT_EN
        check("retire_cnt 10", retire_cnt, 64'd10);
`endif
        check("cnt epoch", cur_epoch, 1);

        // Phase 4: random stimulus against the model
        for (int c = 0; c < 600; c++) begin
            stim_t s;
            s = mk($urandom_range(0, 4) != 0,
                   ($urandom_range(0, 1) != 0) ? 2'(m_epoch) : 2'($urandom),
                   1'($urandom), 5'($urandom), $urandom, $urandom, $urandom,
                   ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00,
                   $urandom_range(0, 9) == 0, 1'($urandom));
            resetn = ($urandom_range(0, 99) != 0);
            drive(s);
            check_model(c);
        end
        resetn = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
